// File: rtl/axi4_mem_pkg.sv
// Shared types, response codes, FSM states and the per-beat address step for the AXI4 burst memory slave.
package axi4_mem_pkg;

  localparam int unsigned MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } burst_cfg_t;

  // WRAP keeps the bits above the (len+1)<<size window and wraps the rest.
  function automatic addr_t next_addr(input addr_t addr, input burst_cfg_t cfg);
    addr_t step;
    addr_t incr;
    addr_t mask;
    step = addr_t'(1) << cfg.size;
    incr = addr + step;
    mask = ((addr_t'(cfg.len) + addr_t'(1)) << cfg.size) - addr_t'(1);
    case (cfg.burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-path beat address generator: word index and error flag for the current (or next) beat.
// WRAP bursts are legal only when AXI4_MEM_WRAP_EN is defined.
module axi4_burst_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                LOOKAHEAD = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic                       step_i,
  input  logic [ADDR_W-1:0]          start_i,
  input  burst_cfg_t                 cfg_i,
  output logic [$clog2(DEPTH)-1:0]   idx_o,
  output logic                       err_o
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned MEM_W = OFF_W + IDX_W;

  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  burst_cfg_t        cfg_q, cfg_d, sel_cfg;

  function automatic logic cfg_err(input burst_cfg_t c);
    logic wrap_bad;
`ifdef AXI4_MEM_WRAP_EN
    wrap_bad = !(c.len inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
    wrap_bad = 1'b1;
`endif
    cfg_err = (32'(c.size) > OFF_W) || (c.burst == 2'b11) ||
              ((c.burst == BURST_WRAP) && wrap_bad);
  endfunction

  // BASE_ADDR is aligned to the memory size, so the upper bits alone decide range.
  function automatic logic range_err(input logic [ADDR_W-1:0] a);
    range_err = (a[ADDR_W-1:MEM_W] != BASE_ADDR[ADDR_W-1:MEM_W]);
  endfunction

  always_comb begin
    addr_d = addr_q;
    cfg_d  = cfg_q;
    if (load_i) begin
      addr_d = start_i;
      cfg_d  = cfg_i;
    end else if (step_i) begin
      addr_d = ADDR_W'(next_addr(addr_t'(addr_q), cfg_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      cfg_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cfg_q  <= cfg_d;
    end
  end

  // Read path looks one beat ahead so its data register can be loaded on the handshake edge.
  assign sel_addr = LOOKAHEAD ? addr_d : addr_q;
  assign sel_cfg  = LOOKAHEAD ? cfg_d : cfg_q;
  assign idx_o    = sel_addr[OFF_W +: IDX_W];
  assign err_o    = cfg_err(sel_cfg) || range_err(sel_addr);

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave with independent write and read FSMs sharing one word array.
// WRAP burst support is enabled by defining AXI4_MEM_WRAP_EN.
module axi4_burst_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [ID_W-1:0]     awid,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [ID_W-1:0]     bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [ID_W-1:0]     arid,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic [ID_W-1:0]     rid
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_e        w_state_q, w_state_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [7:0]      w_beat_q, w_beat_d, w_len_q, w_len_d;
  logic            w_err_q, w_err_d, w_last_beat;

  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [7:0]      r_beat_q, r_beat_d, r_len_q, r_len_d;
  logic [DATA_W-1:0] rdata_q;
  logic            rd_load;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             w_addr_err, r_addr_err;
  burst_cfg_t       aw_cfg, ar_cfg;

  assign aw_fire = awvalid & awready_q;
  assign w_fire  = wvalid & wready_q;
  assign b_fire  = bvalid_q & bready;
  assign ar_fire = arvalid & arready_q;
  assign r_fire  = rvalid_q & rready;

  assign aw_cfg = '{len: awlen, size: awsize, burst: awburst};
  assign ar_cfg = '{len: arlen, size: arsize, burst: arburst};

  axi4_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b0)
  ) u_wr_addr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (aw_fire),
    .step_i  (w_fire),
    .start_i (awaddr),
    .cfg_i   (aw_cfg),
    .idx_o   (w_idx),
    .err_o   (w_addr_err)
  );

  axi4_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b1)
  ) u_rd_addr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ar_fire),
    .step_i  (r_fire & ~rlast_q),
    .start_i (araddr),
    .cfg_i   (ar_cfg),
    .idx_o   (r_idx),
    .err_o   (r_addr_err)
  );

  // Write FSM: burst length is taken from the beat counter; wlast only feeds the error flag.
  always_comb begin
    w_state_d   = w_state_q;
    w_beat_d    = w_beat_q;
    w_len_d     = w_len_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    w_last_beat = (w_beat_q == w_len_q);
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          w_state_d = W_DATA;
          w_beat_d  = 8'd0;
          w_len_d   = awlen;
          w_err_d   = 1'b0;
          bid_d     = awid;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_beat_d = w_beat_q + 8'd1;
          w_err_d  = w_err_q | w_addr_err | (wlast != w_last_beat);
          if (w_last_beat) begin
            w_state_d = W_RESP;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (b_fire) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read FSM: the next beat's response is registered on the AR or previous R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_beat_d  = r_beat_q;
    r_len_d   = r_len_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rd_load   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_DATA;
          r_beat_d  = 8'd0;
          r_len_d   = arlen;
          rid_d     = arid;
          rlast_d   = (arlen == 8'd0);
          rd_load   = 1'b1;
        end
      end
      R_DATA: begin
        if (r_fire) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            rlast_d  = (r_beat_d == r_len_q);
            rd_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_load) rresp_d = r_addr_err ? RESP_SLVERR : RESP_OKAY;
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      w_beat_q  <= 8'd0;
      w_len_q   <= 8'd0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      r_beat_q  <= 8'd0;
      r_len_q   <= 8'd0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      w_beat_q  <= w_beat_d;
      w_len_q   <= w_len_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      r_beat_q  <= r_beat_d;
      r_len_q   <= r_len_d;
      if (rd_load) rdata_q <= r_addr_err ? '0 : mem[r_idx];
    end
  end

  // Byte-lane writes; the array has no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && !w_addr_err) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;

endmodule
